wb_unit: RTL and testbench
==========================

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL take parameter N, default globals_sv::N (4): bits per activation element.
REQ-002 SHALL take parameter W, default globals_sv::W (8): elements per result word; word = N*W bits, half = N*W/2 bits.
REQ-003 SHALL take parameter AW, default CLOG2M+CLOG2W: bank address width.
REQ-004 SHALL take parameter FD, default 4: queue depth (power of 2, >=2).
REQ-005 ck  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 i_wr  in  1  result beat valid (dp o_data_wr).
REQ-008 i_wrh  in  1  1 = half-word beat.
REQ-009 i_wrh_l_n  in  1  half select: 1 = lower half [N*W/2-1:0], 0 = upper half.
REQ-010 i_ev_odd_n  in  1  bank select: 1 = odd, 0 = even.
REQ-011 i_even_addr, i_odd_addr  in  AW each  target address per bank.
REQ-012 i_data  in  N*W  result word; half beats carry data in the selected half's bit positions.
REQ-013 i_flush  in  1  push any pending half (FSM done).
REQ-014 mem_rdy  in  1  memory accepts a write this cycle.
REQ-015 o_even_we / o_odd_we  out  1  one-cycle bank write strobe.
REQ-016 o_even_addr / o_odd_addr  out  AW  write address.
REQ-017 o_even_data / o_odd_data  out  N*W  write data.
REQ-018 o_even_mask / o_odd_mask  out  2  half enables {upper,lower}.
REQ-019 o_idle  out  1  no pending half, queue empty.
REQ-020 o_ovf  out  1  sticky overflow flag.
REQ-021 o_wcount  out  16  count of strobed writes, wraps modulo 2^16.

Function
REQ-022 Pending register SHALL hold at most one half {bank, addr, data, half}; queue SHALL accept up to 2 pushes per cycle in program order.
REQ-023 Full beat (i_wr=1, i_wrh=0): push pending first if present, then push {bank, addr, data, mask 11}.
REQ-024 Half beat, no pending: capture into pending; no push.
REQ-025 Half beat, pending with same bank, same addr, opposite half: push merged word with mask 11; clear pending.
REQ-026 Half beat, pending with any other bank, addr or same half: push pending with its single-half mask, then capture the new half.
REQ-027 i_flush SHALL be evaluated after the same-cycle beat; any pending left is pushed that cycle.
REQ-028 Queue head SHALL drive the selected bank's addr/data/mask combinationally; we = (queue non-empty & mem_rdy); other bank we = 0; pop on we.
REQ-029 Latency: full or completing-half beat at edge t SHALL strobe at t+1 when queue was empty and mem_rdy=1.
REQ-030 Push and pop in the same cycle SHALL be legal at full occupancy.
REQ-031 Pushes exceeding free space after the same-cycle pop SHALL drop the excess newest entries and set o_ovf until reset.
REQ-032 Idle bank outputs SHALL be zero; o_idle SHALL be combinational.
REQ-033 o_wcount SHALL increment once per asserted we.

Reset
REQ-034 rst SHALL clear pending, queue pointers, o_ovf and o_wcount; all outputs 0 except o_idle = 1 the cycle after.
REQ-035 rst mid-operation SHALL discard pending and queued writes without strobing them.

Structure
REQ-036 N, W, CLOG2M, CLOG2W and the packed queue-entry typedef SHALL live in globals_sv.
REQ-037 Queue SHALL be one sub-module wb_fifo (2-push, 1-pop, occupancy count).

Verification
REQ-038 Full beat even, addr 5, data 0x12345678, mem_rdy=1 -> next cycle o_even_we=1, addr 5, data 0x12345678, mask 11.
REQ-039 Half lower odd addr 3 data 0x0000ABCD, then half upper odd addr 3 data 0x12340000 -> single odd write, data 0x1234ABCD, mask 11, o_wcount=1.
REQ-040 Half lower even addr 2, then half lower even addr 4 -> addr 2 mask 01 strobed; addr 4 pending; i_flush -> addr 4 mask 01 strobed.
REQ-041 mem_rdy=0, 5 full beats, FD=4 -> o_ovf=1, only first 4 drained in order once mem_rdy=1.
REQ-042 Pending half plus 2 queued entries, rst asserted -> no strobes afterwards, o_idle=1, o_wcount=0.
REQ-043 Pending half plus full beat to the other bank, same cycle -> pending strobed before full beat on consecutive cycles.

Source files
------------

// File: rtl/globals_sv.sv
// Shared widths and the write-queue entry type for the write-back unit.
package globals_sv;

  localparam int unsigned N      = 4;
  localparam int unsigned W      = 8;
  localparam int unsigned CLOG2M = 4;
  localparam int unsigned CLOG2W = 3;

  localparam int unsigned DW = N * W;
  localparam int unsigned AW = CLOG2M + CLOG2W;

  // One bank write: bank (1 = odd), address, full word and {upper,lower} enables.
  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    mask;
  } wb_entry_t;

  // Single-half write entry; data is expected to carry only the selected half.
  function automatic wb_entry_t half_entry(input logic          bank,
                                           input logic [AW-1:0] addr,
                                           input logic [DW-1:0] data,
                                           input logic          lower);
    wb_entry_t e;
    e.bank = bank;
    e.addr = addr;
    e.data = data;
    e.mask = lower ? 2'b01 : 2'b10;
    return e;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Write queue: up to two pushes per cycle (push0 older than push1), one pop.
// Ports: ck/rst clock and sync reset; push0_v/push0, push1_v/push1 entries in
// program order; pop removes head; head is the oldest entry; count is the
// occupancy; drop flags that at least one push did not fit this cycle.
module wb_fifo
  import globals_sv::*;
#(
  parameter int unsigned FD = 4
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   push0_v,
  input  wb_entry_t              push0,
  input  logic                   push1_v,
  input  wb_entry_t              push1,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(FD):0]    count,
  output logic                   drop
);

  localparam int unsigned PW = $clog2(FD);
  localparam int unsigned CW = PW + 1;

  wb_entry_t     mem [FD];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] free;
  logic          acc0;
  logic          acc1;

  // Space freed by this cycle's pop is usable by this cycle's pushes.
  always_comb begin
    free = CW'(FD) - count + CW'(pop);
    acc0 = push0_v && (free >= CW'(1));
    acc1 = push1_v && (free >= CW'(2));
    drop = (push0_v && !acc0) || (push1_v && !acc1);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + PW'(acc0) + PW'(acc1);
      rp    <= rp + PW'(pop);
      count <= count + CW'(acc0) + CW'(acc1) - CW'(pop);
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge ck) begin
    if (acc0) mem[wp] <= push0;
    if (acc1) mem[wp + PW'(1)] <= push1;
  end

  assign head = mem[rp];

endmodule

// File: rtl/wb_unit.sv
// Write-back unit: merges half-word result beats into full-word bank writes
// and queues them for the even/odd memory banks.
// Ports: ck/rst clock and sync reset; i_wr/i_wrh/i_wrh_l_n/i_ev_odd_n beat
// control; i_even_addr/i_odd_addr/i_data beat payload; i_flush pushes any
// pending half; mem_rdy memory ready; o_{even,odd}_{we,addr,data,mask} bank
// write ports; o_idle nothing pending or queued; o_ovf sticky drop flag;
// o_wcount strobed-write counter.
module wb_unit #(
  parameter int unsigned N  = globals_sv::N,
  parameter int unsigned W  = globals_sv::W,
  parameter int unsigned AW = globals_sv::CLOG2M + globals_sv::CLOG2W,
  parameter int unsigned FD = 4
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          i_wr,
  input  logic          i_wrh,
  input  logic          i_wrh_l_n,
  input  logic          i_ev_odd_n,
  input  logic [AW-1:0] i_even_addr,
  input  logic [AW-1:0] i_odd_addr,
  input  logic [N*W-1:0] i_data,
  input  logic          i_flush,
  input  logic          mem_rdy,
  output logic          o_even_we,
  output logic [AW-1:0] o_even_addr,
  output logic [N*W-1:0] o_even_data,
  output logic [1:0]    o_even_mask,
  output logic          o_odd_we,
  output logic [AW-1:0] o_odd_addr,
  output logic [N*W-1:0] o_odd_data,
  output logic [1:0]    o_odd_mask,
  output logic          o_idle,
  output logic          o_ovf,
  output logic [15:0]   o_wcount
);
  import globals_sv::*;

  localparam int unsigned DWD = N * W;
  localparam int unsigned HW  = DWD / 2;
  localparam logic [DWD-1:0] LO_MASK = {{HW{1'b0}}, {HW{1'b1}}};

  logic           pend_v, pend_bank, pend_lower;
  logic [AW-1:0]  pend_addr;
  logic [DWD-1:0] pend_data;
  logic           nxt_v, nxt_bank, nxt_lower;
  logic [AW-1:0]  nxt_addr;
  logic [DWD-1:0] nxt_data;

  logic [AW-1:0]  beat_addr;
  logic [DWD-1:0] half_data;
  wb_entry_t      p0, p1, head;
  logic           p0_v, p1_v, drop, we, empty;
  logic [$clog2(FD):0] count;

  // Beat decode: pending-half bookkeeping and up to two in-order pushes.
  always_comb begin
    nxt_v     = pend_v;
    nxt_bank  = pend_bank;
    nxt_lower = pend_lower;
    nxt_addr  = pend_addr;
    nxt_data  = pend_data;
    p0_v      = 1'b0;
    p1_v      = 1'b0;
    p0        = '0;
    p1        = '0;
    beat_addr = i_ev_odd_n ? i_odd_addr : i_even_addr;
    half_data = i_data & (i_wrh_l_n ? LO_MASK : ~LO_MASK);

    if (i_wr && !i_wrh) begin
      if (pend_v) begin
        p0_v = 1'b1;
        p0   = half_entry(pend_bank, pend_addr, pend_data, pend_lower);
        p1_v = 1'b1;
        p1   = '{bank: i_ev_odd_n, addr: beat_addr, data: i_data, mask: 2'b11};
      end else begin
        p0_v = 1'b1;
        p0   = '{bank: i_ev_odd_n, addr: beat_addr, data: i_data, mask: 2'b11};
      end
      nxt_v = 1'b0;
    end else if (i_wr) begin
      if (pend_v && (pend_bank == i_ev_odd_n) && (pend_addr == beat_addr) &&
          (pend_lower != i_wrh_l_n)) begin
        p0_v  = 1'b1;
        p0    = '{bank: i_ev_odd_n, addr: beat_addr, data: pend_data | half_data,
                  mask: 2'b11};
        nxt_v = 1'b0;
      end else begin
        if (pend_v) begin
          p0_v = 1'b1;
          p0   = half_entry(pend_bank, pend_addr, pend_data, pend_lower);
        end
        nxt_v     = 1'b1;
        nxt_bank  = i_ev_odd_n;
        nxt_lower = i_wrh_l_n;
        nxt_addr  = beat_addr;
        nxt_data  = half_data;
      end
    end

    // Flush sees the pending state left by this cycle's beat.
    if (i_flush && nxt_v) begin
      if (p0_v) begin
        p1_v = 1'b1;
        p1   = half_entry(nxt_bank, nxt_addr, nxt_data, nxt_lower);
      end else begin
        p0_v = 1'b1;
        p0   = half_entry(nxt_bank, nxt_addr, nxt_data, nxt_lower);
      end
      nxt_v = 1'b0;
    end
  end

  wb_fifo #(.FD(FD)) u_fifo (
    .ck      (ck),
    .rst     (rst),
    .push0_v (p0_v),
    .push0   (p0),
    .push1_v (p1_v),
    .push1   (p1),
    .pop     (we),
    .head    (head),
    .count   (count),
    .drop    (drop)
  );

  assign empty = (count == '0);
  assign we    = !empty && mem_rdy;

  // Head drives only its own bank; the other bank stays at zero.
  always_comb begin
    o_even_we   = 1'b0;
    o_even_addr = '0;
    o_even_data = '0;
    o_even_mask = '0;
    o_odd_we    = 1'b0;
    o_odd_addr  = '0;
    o_odd_data  = '0;
    o_odd_mask  = '0;
    if (!empty) begin
      if (head.bank) begin
        o_odd_we   = we;
        o_odd_addr = head.addr;
        o_odd_data = head.data;
        o_odd_mask = head.mask;
      end else begin
        o_even_we   = we;
        o_even_addr = head.addr;
        o_even_data = head.data;
        o_even_mask = head.mask;
      end
    end
  end

  assign o_idle = !pend_v && empty;

  always_ff @(posedge ck) begin
    if (rst) begin
      pend_v     <= 1'b0;
      pend_bank  <= 1'b0;
      pend_lower <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      o_ovf      <= 1'b0;
      o_wcount   <= '0;
    end else begin
      pend_v     <= nxt_v;
      pend_bank  <= nxt_bank;
      pend_lower <= nxt_lower;
      pend_addr  <= nxt_addr;
      pend_data  <= nxt_data;
      if (drop) o_ovf <= 1'b1;
      if (we)   o_wcount <= o_wcount + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard bench for wb_unit: expected bank writes are queued as beats are
// driven and checked in order as strobes appear.
module tb_wb_unit;
  import globals_sv::*;

  logic          ck = 1'b0;
  logic          rst = 1'b1;
  logic          i_wr = 0, i_wrh = 0, i_wrh_l_n = 0, i_ev_odd_n = 0, i_flush = 0;
  logic [AW-1:0] i_even_addr = '0, i_odd_addr = '0;
  logic [DW-1:0] i_data = '0;
  logic          mem_rdy = 1'b0;
  logic          o_even_we, o_odd_we, o_idle, o_ovf;
  logic [AW-1:0] o_even_addr, o_odd_addr;
  logic [DW-1:0] o_even_data, o_odd_data;
  logic [1:0]    o_even_mask, o_odd_mask;
  logic [15:0]   o_wcount;

  int total = 0;
  int bad = 0;
  wb_entry_t sb[$];

  wb_unit dut (
    .ck(ck), .rst(rst), .i_wr(i_wr), .i_wrh(i_wrh), .i_wrh_l_n(i_wrh_l_n),
    .i_ev_odd_n(i_ev_odd_n), .i_even_addr(i_even_addr), .i_odd_addr(i_odd_addr),
    .i_data(i_data), .i_flush(i_flush), .mem_rdy(mem_rdy),
    .o_even_we(o_even_we), .o_even_addr(o_even_addr), .o_even_data(o_even_data),
    .o_even_mask(o_even_mask), .o_odd_we(o_odd_we), .o_odd_addr(o_odd_addr),
    .o_odd_data(o_odd_data), .o_odd_mask(o_odd_mask), .o_idle(o_idle),
    .o_ovf(o_ovf), .o_wcount(o_wcount)
  );

  always #5 ck = ~ck;

  function automatic wb_entry_t mk(input logic b, input int a, input logic [DW-1:0] d,
                                   input logic [1:0] m);
    wb_entry_t e;
    e.bank = b; e.addr = AW'(a); e.data = d; e.mask = m;
    return e;
  endfunction

  // Strobe monitor: in-order scoreboard check plus idle-bank zero check.
  always @(negedge ck) begin
    if (!rst && (o_even_we || o_odd_we)) begin
      wb_entry_t got, exp;
      total++;
      if (o_even_we && o_odd_we) begin
        bad++;
        $display("FAIL both_we: even_we=%b odd_we=%b, required one bank only", o_even_we, o_odd_we);
      end else begin
        got.bank = o_odd_we;
        got.addr = o_odd_we ? o_odd_addr : o_even_addr;
        got.data = o_odd_we ? o_odd_data : o_even_data;
        got.mask = o_odd_we ? o_odd_mask : o_even_mask;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got bank=%0d addr=%0d data=%h mask=%b, required none",
                   got.bank, got.addr, got.data, got.mask);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            bad++;
            $display("FAIL write: got bank=%0d addr=%0d data=%h mask=%b, required bank=%0d addr=%0d data=%h mask=%b",
                     got.bank, got.addr, got.data, got.mask, exp.bank, exp.addr, exp.data, exp.mask);
          end
        end
        total++;
        if (o_odd_we ? ({o_even_addr, o_even_data, o_even_mask} !== '0)
                     : ({o_odd_addr, o_odd_data, o_odd_mask} !== '0)) begin
          bad++;
          $display("FAIL idle_bank: even=%h/%h/%b odd=%h/%h/%b, required other bank zero",
                   o_even_addr, o_even_data, o_even_mask, o_odd_addr, o_odd_data, o_odd_mask);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: sim still running, required finish");
    $fatal(1, "timeout");
  end

  task automatic beat(input logic wr, input logic wrh, input logic lo, input logic odd,
                      input int a, input logic [DW-1:0] d, input logic fl);
    i_wr = wr; i_wrh = wrh; i_wrh_l_n = lo; i_ev_odd_n = odd; i_flush = fl;
    i_even_addr = odd ? ~AW'(a) : AW'(a);
    i_odd_addr  = odd ? AW'(a) : ~AW'(a);
    i_data = d;
    @(posedge ck); #1;
    i_wr = 0; i_wrh = 0; i_wrh_l_n = 0; i_ev_odd_n = 0; i_flush = 0;
    i_even_addr = '0; i_odd_addr = '0; i_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge ck); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || !o_idle) && n < budget) begin
      @(negedge ck); #1;
      n++;
    end
    total++;
    if (sb.size() != 0 || !o_idle) begin
      bad++;
      $display("FAIL drain_timeout: left=%0d idle=%b, required 0 and 1", sb.size(), o_idle);
    end
    @(posedge ck); #1;
  endtask

  task automatic chk_wcount(input string name, input int exp);
    total++;
    if (o_wcount !== 16'(exp)) begin
      bad++;
      $display("FAIL %s: wcount=%0d, required %0d", name, o_wcount, exp);
    end
  endtask

  task automatic test_reset();
    mem_rdy = 1'b1;
    do_reset();
    @(negedge ck);
    total++;
    if (o_idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b, required 1", o_idle); end
    total++;
    if ({o_even_we, o_even_addr, o_even_data, o_even_mask, o_odd_we, o_odd_addr,
         o_odd_data, o_odd_mask, o_ovf, o_wcount} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: even_we=%b odd_we=%b ovf=%b wcount=%0d, required all zero",
               o_even_we, o_odd_we, o_ovf, o_wcount);
    end
    @(posedge ck); #1;
  endtask

  task automatic test_full_beat();
    mem_rdy = 1'b1;
    do_reset();
    sb.push_back(mk(0, 5, 32'h12345678, 2'b11));
    beat(1, 0, 0, 0, 5, 32'h12345678, 0);
    @(negedge ck);
    total++;
    if (!(o_even_we === 1'b1 && o_even_addr === AW'(5) && o_even_data === 32'h12345678 &&
          o_even_mask === 2'b11)) begin
      bad++;
      $display("FAIL full_latency: we=%b addr=%0d data=%h mask=%b, required 1/5/12345678/11",
               o_even_we, o_even_addr, o_even_data, o_even_mask);
    end
    wait_drain(10);
    chk_wcount("full_wcount", 1);
  endtask

  task automatic test_merge();
    mem_rdy = 1'b1;
    do_reset();
    sb.push_back(mk(1, 3, 32'h1234ABCD, 2'b11));
    beat(1, 1, 1, 1, 3, 32'h0000ABCD, 0);
    total++;
    if (o_idle !== 1'b0) begin bad++; $display("FAIL merge_pending: idle=%b, required 0", o_idle); end
    beat(1, 1, 0, 1, 3, 32'h12340000, 0);
    wait_drain(10);
    chk_wcount("merge_wcount", 1);
  endtask

  task automatic test_flush();
    mem_rdy = 1'b1;
    do_reset();
    sb.push_back(mk(0, 2, 32'h00002222, 2'b01));
    sb.push_back(mk(0, 4, 32'h00003333, 2'b01));
    beat(1, 1, 1, 0, 2, 32'h00002222, 0);
    beat(1, 1, 1, 0, 4, 32'h00003333, 0);
    @(negedge ck); #1;
    total++;
    if (sb.size() !== 1 || o_idle !== 1'b0) begin
      bad++;
      $display("FAIL flush_pending: left=%0d idle=%b, required 1 and 0", sb.size(), o_idle);
    end
    @(posedge ck); #1;
    beat(0, 0, 0, 0, 0, '0, 1);
    wait_drain(10);
    chk_wcount("flush_wcount", 2);
  endtask

  task automatic test_overflow();
    mem_rdy = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back(mk(0, i, 32'h1000 + 32'(i), 2'b11));
      beat(1, 0, 0, 0, i, 32'h1000 + 32'(i), 0);
    end
    total++;
    if (o_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b, required 1", o_ovf); end
    mem_rdy = 1'b1;
    wait_drain(20);
    chk_wcount("ovf_wcount", 4);
    total++;
    if (o_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b, required 1", o_ovf); end
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    mem_rdy = 1'b0;
    do_reset();
    beat(1, 0, 0, 0, 1, 32'hAAAA0001, 0);
    beat(1, 0, 0, 1, 2, 32'hAAAA0002, 0);
    beat(1, 1, 1, 0, 7, 32'h00000007, 0);
    total++;
    if (o_idle !== 1'b0) begin bad++; $display("FAIL mid_busy: idle=%b, required 0", o_idle); end
    do_reset();
    mem_rdy = 1'b1;
    repeat (6) begin
      @(negedge ck);
      if (o_even_we || o_odd_we) strobes++;
    end
    total++;
    if (strobes !== 0 || o_idle !== 1'b1 || o_wcount !== 16'd0 || o_ovf !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: strobes=%0d idle=%b wcount=%0d ovf=%b, required 0/1/0/0",
               strobes, o_idle, o_wcount, o_ovf);
    end
    @(posedge ck); #1;
  endtask

  task automatic test_back_to_back();
    mem_rdy = 1'b1;
    do_reset();
    sb.push_back(mk(1, 9, 32'hAAAA0000, 2'b10));
    sb.push_back(mk(0, 6, 32'h55667788, 2'b11));
    beat(1, 1, 0, 1, 9, 32'hAAAA0000, 0);
    beat(1, 0, 0, 0, 6, 32'h55667788, 0);
    @(negedge ck);
    total++;
    if (o_odd_we !== 1'b1 || o_even_we !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first: odd_we=%b even_we=%b, required 1/0", o_odd_we, o_even_we);
    end
    @(negedge ck);
    total++;
    if (o_even_we !== 1'b1 || o_odd_we !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second: even_we=%b odd_we=%b, required 1/0", o_even_we, o_odd_we);
    end
    @(posedge ck); #1;
    wait_drain(10);
    chk_wcount("b2b_wcount", 2);
  endtask

  task automatic test_stream();
    int issued = 0;
    mem_rdy = 1'b1;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      logic [DW-1:0] d;
      logic          b;
      int            a;
      mem_rdy = ($urandom_range(0, 3) != 0);
      if (sb.size() < 3 && $urandom_range(0, 2) != 0) begin
        d = DW'($urandom);
        b = 1'($urandom_range(0, 1));
        a = int'($urandom_range(0, (1 << AW) - 1));
        sb.push_back(mk(b, a, d, 2'b11));
        issued++;
        beat(1, 0, 0, b, a, d, 0);
      end else begin
        @(posedge ck); #1;
      end
    end
    mem_rdy = 1'b1;
    wait_drain(20);
    chk_wcount("stream_wcount", issued);
    total++;
    if (o_ovf !== 1'b0) begin bad++; $display("FAIL stream_ovf: got %b, required 0", o_ovf); end
  endtask

  initial begin
    repeat (2) @(posedge ck);
    #1;
    test_reset();
    test_full_beat();
    test_merge();
    test_flush();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
